// File: rtl/bus_wdt.sv
// Bus-cycle watchdog: times each CPU bus cycle and drives berr_n when no dtack/vpa termination arrives.
// Optional build macro BUS_WDT_IACK_EXEMPT_EN: interrupt-acknowledge cycles (fc=7) are not timed.
module bus_wdt #(
    parameter int TIMEOUT     = 64,
    parameter int VPA_TIMEOUT = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        as_n,
    input  logic        dtack_n,
    input  logic        vpa_n,
    input  logic [2:0]  cpu_fc,
    input  logic [22:0] cpu_addrbus,
    input  logic        clr_fault_n,
    output logic        berr_n,
    output logic        fault_valid,
    output logic [22:0] fault_addr,
    output logic [2:0]  fault_fc,
    output logic [7:0]  fault_cnt
);

    // state    | meaning
    // IDLE     | no bus cycle being timed
    // COUNT    | cycle in progress, counter running toward the active limit
    // BERR     | timeout hit, berr_n held low until as_n is sampled high
    // WAIT_END | cycle terminated (or exempt), waiting for as_n high
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT    = 2'd1,
        S_BERR     = 2'd2,
        S_WAIT_END = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIM_DTACK = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LIM_VPA   = CNT_W'(VPA_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit;
    logic             vpa_seen_q;
    logic             vpa_seen_d;
    logic             shadow_load;
    logic [22:0]      shadow_addr_q;
    logic [2:0]       shadow_fc_q;
    logic             fault_event;
    logic             iack_exempt;
    logic             berr_n_q;
    logic             fault_valid_q;
    logic [22:0]      fault_addr_q;
    logic [2:0]       fault_fc_q;
    logic [7:0]       fault_cnt_q;

`ifdef BUS_WDT_IACK_EXEMPT_EN
    assign iack_exempt = (cpu_fc == 3'b111);
`else
    assign iack_exempt = 1'b0;
`endif

    // vpa_n seen this edge already selects the slow limit, so the compare below uses it at once.
    assign limit = (vpa_seen_q || !vpa_n) ? LIM_VPA : LIM_DTACK;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vpa_seen_d  = vpa_seen_q;
        shadow_load = 1'b0;
        fault_event = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!as_n && en) begin
                    if (iack_exempt) begin
                        state_d = S_WAIT_END;
                    end else begin
                        state_d     = S_COUNT;
                        cnt_d       = CNT_ONE;
                        vpa_seen_d  = 1'b0;
                        shadow_load = 1'b1;
                    end
                end
            end
            S_COUNT: begin
                if (as_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!dtack_n) begin
                    state_d = S_WAIT_END;
                end else begin
                    if (!vpa_n) begin
                        vpa_seen_d = 1'b1;
                    end
                    // >= rather than == keeps a late switch to a smaller limit from wrapping
                    if (cnt_q >= limit) begin
                        state_d     = S_BERR;
                        fault_event = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_BERR: begin
                if (as_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_WAIT_END: begin
                if (as_n) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            vpa_seen_q <= 1'b0;
            berr_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vpa_seen_q <= vpa_seen_d;
            berr_n_q   <= (state_d != S_BERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_addr_q <= '0;
            shadow_fc_q   <= '0;
        end else if (shadow_load) begin
            shadow_addr_q <= cpu_addrbus;
            shadow_fc_q   <= cpu_fc;
        end
    end

    // First fault wins unless a clear lands on the same edge, in which case the new fault is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_fc_q    <= '0;
            fault_cnt_q   <= '0;
        end else if (fault_event) begin
            if (fault_cnt_q != 8'hFF) begin
                fault_cnt_q <= fault_cnt_q + 8'd1;
            end
            if (!fault_valid_q || !clr_fault_n) begin
                fault_valid_q <= 1'b1;
                fault_addr_q  <= shadow_addr_q;
                fault_fc_q    <= shadow_fc_q;
            end
        end else if (!clr_fault_n) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign berr_n      = berr_n_q;
    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_fc    = fault_fc_q;
    assign fault_cnt   = fault_cnt_q;

    berr_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        berr_n_q == (state_q != S_BERR));

endmodule

// File: tb/tb_bus_wdt.sv
// Self-checking bench for bus_wdt: table of bus cycles with expected berr timing and fault state.
module tb_bus_wdt;
    localparam int TIMEOUT     = 64;
    localparam int VPA_TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        as_n = 1'b1;
    logic        dtack_n = 1'b1;
    logic        vpa_n = 1'b1;
    logic [2:0]  cpu_fc = 3'd0;
    logic [22:0] cpu_addrbus = 23'd0;
    logic        clr_fault_n = 1'b1;
    logic        berr_n;
    logic        fault_valid;
    logic [22:0] fault_addr;
    logic [2:0]  fault_fc;
    logic [7:0]  fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bus_wdt #(
        .TIMEOUT(TIMEOUT),
        .VPA_TIMEOUT(VPA_TIMEOUT),
        .CNT_W(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .as_n(as_n),
        .dtack_n(dtack_n),
        .vpa_n(vpa_n),
        .cpu_fc(cpu_fc),
        .cpu_addrbus(cpu_addrbus),
        .clr_fault_n(clr_fault_n),
        .berr_n(berr_n),
        .fault_valid(fault_valid),
        .fault_addr(fault_addr),
        .fault_fc(fault_fc),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Cycle offsets k count rising edges from the first edge that samples as_n low (k=0).
    typedef struct {
        logic [22:0] addr;
        logic [2:0]  fc;
        int          hold;
        int          dtack_at;
        int          vpa_at;
        int          clr_at;
        int          en_off_at;
        int          exp_berr_edge;
        logic        exp_fv;
        logic [22:0] exp_faddr;
        logic [2:0]  exp_ffc;
        logic [7:0]  exp_fcnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Entered and left at a falling edge; as_n is high for exactly one sample between calls.
    task automatic run_bus(input vec_t v, output int berr_edge, output logic berr_rel);
        as_n        = 1'b0;
        cpu_addrbus = v.addr;
        cpu_fc      = v.fc;
        dtack_n     = 1'b1;
        vpa_n       = 1'b1;
        berr_edge   = -1;
        for (int k = 0; k < v.hold; k++) begin
            if (k == v.dtack_at)  dtack_n = 1'b0;
            if (k == v.vpa_at)    vpa_n = 1'b0;
            if (k == v.en_off_at) en = 1'b0;
            clr_fault_n = (k == v.clr_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (!berr_n && berr_edge < 0) berr_edge = k;
        end
        clr_fault_n = 1'b1;
        as_n        = 1'b1;
        dtack_n     = 1'b1;
        vpa_n       = 1'b1;
        @(negedge clk);
        berr_rel = berr_n;
        en       = 1'b1;
    endtask

    vec_t cur;
    vec_t e;
    int   be;
    logic rel;
    int   w;

    initial begin
        //            addr         fc    hold dtk  vpa  clr  enoff berr fv    faddr        ffc   fcnt
        vecs[0]  = '{23'h123456, 3'd6,   7,   5,  -1,  -1,  -1,  -1, 1'b0, 23'h000000, 3'd0, 8'd0};
        vecs[1]  = '{23'h7FFF00, 3'd5,  70,  -1,  -1,  -1,  -1,  64, 1'b1, 23'h7FFF00, 3'd5, 8'd1};
        vecs[2]  = '{23'h000400, 3'd1, 200,  -1,   3,  -1,  -1,  -1, 1'b1, 23'h7FFF00, 3'd5, 8'd1};
        vecs[3]  = '{23'h000500, 3'd2, 300,  -1,   3,  -1,  -1, 256, 1'b1, 23'h7FFF00, 3'd5, 8'd2};
        vecs[4]  = '{23'h000580, 3'd6,  70,  64,  -1,  -1,  -1,  -1, 1'b1, 23'h7FFF00, 3'd5, 8'd2};
        vecs[5]  = '{23'h000600, 3'd1,   4,   1,  -1,   2,  -1,  -1, 1'b0, 23'h7FFF00, 3'd5, 8'd2};
        vecs[6]  = '{23'h000100, 3'd6,  66,  -1,  -1,  -1,  -1,  64, 1'b1, 23'h000100, 3'd6, 8'd3};
        vecs[7]  = '{23'h000200, 3'd2,  66,  -1,  -1,  -1,  -1,  64, 1'b1, 23'h000100, 3'd6, 8'd4};
        vecs[8]  = '{23'h000610, 3'd1,   4,   1,  -1,   2,  -1,  -1, 1'b0, 23'h000100, 3'd6, 8'd4};
        vecs[9]  = '{23'h000300, 3'd1,  66,  -1,  -1,  -1,  -1,  64, 1'b1, 23'h000300, 3'd1, 8'd5};
        vecs[10] = '{23'h000700, 3'd5,  70,  -1,  -1,  64,  -1,  64, 1'b1, 23'h000700, 3'd5, 8'd6};
        vecs[11] = '{23'h000800, 3'd5,  70,  -1,  -1,  -1,  30,  -1, 1'b1, 23'h000700, 3'd5, 8'd6};
`ifdef BUS_WDT_IACK_EXEMPT_EN
        vecs[12] = '{23'h7FFFFE, 3'd7, 100,  -1,  -1,  -1,  -1,  -1, 1'b1, 23'h000700, 3'd5, 8'd6};
`else
        vecs[12] = '{23'h7FFFFE, 3'd7, 100,  -1,  -1,  -1,  -1,  64, 1'b1, 23'h000700, 3'd5, 8'd7};
`endif

        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_berr_n", {31'd0, berr_n}, 32'd1);
        chk("reset_fault_valid", {31'd0, fault_valid}, 32'd0);
        chk("reset_fault_addr", {9'd0, fault_addr}, 32'd0);
        chk("reset_fault_fc", {29'd0, fault_fc}, 32'd0);
        chk("reset_fault_cnt", {24'd0, fault_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(vecs[i]);
            run_bus(vecs[i], be, rel);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_berr_edge", i), be, e.exp_berr_edge);
            chk($sformatf("v%0d_berr_release", i), {31'd0, rel}, 32'd1);
            chk($sformatf("v%0d_fault_valid", i), {31'd0, fault_valid}, {31'd0, e.exp_fv});
            chk($sformatf("v%0d_fault_addr", i), {9'd0, fault_addr}, {9'd0, e.exp_faddr});
            chk($sformatf("v%0d_fault_fc", i), {29'd0, fault_fc}, {29'd0, e.exp_ffc});
            chk($sformatf("v%0d_fault_cnt", i), {24'd0, fault_cnt}, {24'd0, e.exp_fcnt});
        end

        // Saturation: enough back-to-back timeouts to pass 255 from any earlier count.
        cur = '{23'h001000, 3'd2, 66, -1, -1, -1, -1, 64, 1'b1, 23'h000700, 3'd5, 8'hFF};
        for (int i = 0; i < 252; i++) run_bus(cur, be, rel);
        chk("sat_fault_cnt", {24'd0, fault_cnt}, 32'd255);
        chk("sat_fault_addr_held", {9'd0, fault_addr}, 32'h000700);

        // Hung cycle: berr survives en dropping, then async reset releases it immediately.
        as_n        = 1'b0;
        cpu_addrbus = 23'h0ABCDE;
        cpu_fc      = 3'd3;
        w = 0;
        while (berr_n && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("hung_berr_asserted", {31'd0, berr_n}, 32'd0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("berr_held_en_low", {31'd0, berr_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_berr_n", {31'd0, berr_n}, 32'd1);
        chk("async_rst_fault_valid", {31'd0, fault_valid}, 32'd0);
        chk("async_rst_fault_addr", {9'd0, fault_addr}, 32'd0);
        chk("async_rst_fault_fc", {29'd0, fault_fc}, 32'd0);
        chk("async_rst_fault_cnt", {24'd0, fault_cnt}, 32'd0);
        as_n = 1'b1;
        en   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cur = '{23'h0ABCDE, 3'd3, 66, -1, -1, -1, -1, 64, 1'b1, 23'h0ABCDE, 3'd3, 8'd1};
        exp_q.push_back(cur);
        run_bus(cur, be, rel);
        e = exp_q.pop_front();
        chk("post_rst_berr_edge", be, e.exp_berr_edge);
        chk("post_rst_fault_addr", {9'd0, fault_addr}, {9'd0, e.exp_faddr});
        chk("post_rst_fault_fc", {29'd0, fault_fc}, {29'd0, e.exp_ffc});
        chk("post_rst_fault_cnt", {24'd0, fault_cnt}, {24'd0, e.exp_fcnt});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
